d_phy_lane_receiver: RTL and testbench

Single-lane MIPI D-PHY high-speed (HS) receiver front end. It deserializes one lane's bit stream and locks byte alignment on the HS sync byte. It then emits one 8-bit byte per 8 received bits, with a one-cycle enable strobe. One instance per lane feeds the CSI-2 packet layer, which resets the lane at the end of each packet.

---
 rtl/d_phy_pkg.sv | 6 +
 rtl/d_phy_lane_receiver_if.sv | 14 +
 rtl/d_phy_lane_receiver.sv | 59 +++++
 tb/tb_d_phy_lane_receiver.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_phy_pkg.sv
// d_phy_pkg: shared constants and lane state type for the D-PHY lane receiver
package d_phy_pkg;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;
   localparam int BYTE_BITS = 8;
   typedef enum logic {HUNT, RECEIVE} lane_state_t;
endpackage

// File: rtl/d_phy_lane_receiver_if.sv
// d_phy_lane_receiver_if: lane pins in, deserialized byte stream out, for one D-PHY lane
interface d_phy_lane_receiver_if
   import d_phy_pkg::*;
#(
   parameter int W = BYTE_BITS
);
   logic         data_p_i;
   logic         data_n_i;
   logic [W-1:0] data_o;
   logic         enable_o;
   logic         synced_o;
   modport master (output data_p_i, data_n_i, input data_o, enable_o, synced_o);
   modport slave (input data_p_i, data_n_i, output data_o, enable_o, synced_o);
endinterface

// File: rtl/d_phy_lane_receiver.sv
// d_phy_lane_receiver: HS lane deserializer, locks byte alignment on the sync byte.
// Define D_PHY_DIFF_CHECK_EN to drop the lane back to HUNT when data_n != ~data_p.
module d_phy_lane_receiver
   import d_phy_pkg::*;
#(
   parameter int                    DATA_WIDTH = BYTE_BITS,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
   input logic                  clock_i,
   input logic                  reset_ni,
   d_phy_lane_receiver_if.slave lane
);
   localparam int CNT_W = $clog2(DATA_WIDTH);
   lane_state_t           state_q;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  enable_q;
   logic                  diff_err;
`ifdef D_PHY_DIFF_CHECK_EN
   assign diff_err = lane.data_n_i == lane.data_p_i;
`else
   assign diff_err = 1'b0;
`endif
   // Newest bit enters at the top so the earliest bit ends up in bit 0.
   assign shift_d = {lane.data_p_i, shift_q[DATA_WIDTH-1:1]};
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= HUNT;
         shift_q  <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         enable_q <= 1'b0;
      end else begin
         enable_q <= 1'b0;
         if (diff_err) begin
            state_q <= HUNT;
            shift_q <= '0;
            cnt_q   <= '0;
         end else begin
            shift_q <= shift_d;
            if (state_q == HUNT) begin
               if (shift_d == SYNC_BYTE) begin
                  state_q <= RECEIVE;
                  cnt_q   <= '0;
               end
            end else begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  data_q   <= shift_d;
                  enable_q <= 1'b1;
               end
            end
         end
      end
   end
   assign lane.data_o   = data_q;
   assign lane.enable_o = enable_q;
   assign lane.synced_o = (state_q == RECEIVE);
endmodule

// File: tb/tb_d_phy_lane_receiver.sv
// tb_d_phy_lane_receiver: checks the lane receiver against a bit-stream reference model.
module tb_d_phy_lane_receiver;
   import d_phy_pkg::*;
`ifdef D_PHY_DIFF_CHECK_EN
   localparam bit DIFF = 1'b1;
`else
   localparam bit DIFF = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   stim[$];
   bit   sbad[$];
   bit   hist[$];
   bit   pay[$];
   bit   m_sync, m_en;
   bit [7:0] m_data;

   d_phy_lane_receiver_if lane ();
   d_phy_lane_receiver dut (.clock_i(clk), .reset_ni(rst_n), .lane(lane.slave));

   always #5 clk = ~clk;

   // Model: an 8-bit window of the most recent bits (zeros after reset/clear) and a payload bit list.
   task automatic clear_hist();
      hist.delete();
      repeat (8) hist.push_back(1'b0);
   endtask

   task automatic model_reset();
      m_sync = 0;
      m_en   = 0;
      m_data = 8'h00;
      pay.delete();
      clear_hist();
   endtask

   function automatic int window();
      int v = 0;
      foreach (hist[i]) v += int'(hist[i]) << i;
      return v;
   endfunction

   task automatic model_step(input bit p, input bit bad);
      m_en = 0;
      if (DIFF && bad) begin
         m_sync = 0;
         pay.delete();
         clear_hist();
      end else if (!m_sync) begin
         hist.push_back(p);
         void'(hist.pop_front());
         if (window() == int'(SYNC_BYTE_DEFAULT)) begin
            m_sync = 1;
            pay.delete();
         end
      end else begin
         pay.push_back(p);
         if (pay.size() == 8) begin
            foreach (pay[i]) m_data[i] = pay[i];
            m_en = 1;
            pay.delete();
         end
      end
   endtask

   task automatic add_bit(input bit p, input bit bad);
      stim.push_back(p);
      sbad.push_back(bad);
   endtask

   task automatic add_byte(input bit [7:0] b);
      for (int i = 0; i < 8; i++) add_bit(b[i], 1'b0);
   endtask

   task automatic send_bit(input bit p, input bit bad);
      @(negedge clk);
      lane.data_p_i = p;
      lane.data_n_i = bad ? p : ~p;
      @(posedge clk);
      #1;
      model_step(p, bad);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      lane.data_p_i = 1'b0;
      lane.data_n_i = 1'b1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      stim.delete();
      sbad.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      lane.data_p_i = 1'b0;
      lane.data_n_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({lane.enable_o, lane.synced_o, lane.data_o} !== 10'h000) begin
         errors++;
         $display("FAIL reset_hold: got en=%b sync=%b data=%h want 0 0 00", lane.enable_o, lane.synced_o, lane.data_o);
      end
      apply_reset();
      @(posedge clk);
      #1;
      checks++;
      if ({lane.enable_o, lane.synced_o, lane.data_o} !== 10'h000) begin
         errors++;
         $display("FAIL reset_release: got en=%b sync=%b data=%h want 0 0 00", lane.enable_o, lane.synced_o, lane.data_o);
      end
   endtask

   task automatic test_basic();
      bit [7:0] got[$];
      int at[$];
      apply_reset();
      add_byte(SYNC_BYTE_DEFAULT);
      add_byte(8'h12);
      add_byte(8'h34);
      foreach (stim[i]) begin
         send_bit(stim[i], sbad[i]);
         checks++;
         if ({lane.enable_o, lane.synced_o, lane.data_o} !== {m_en, m_sync, m_data}) begin
            errors++;
            $display("FAIL basic bit %0d: got en=%b sync=%b data=%h want en=%b sync=%b data=%h", i, lane.enable_o, lane.synced_o, lane.data_o, m_en, m_sync, m_data);
         end
         if (lane.enable_o) begin
            got.push_back(lane.data_o);
            at.push_back(i);
         end
      end
      checks++;
      if (got.size() != 2 || got[0] !== 8'h12 || got[1] !== 8'h34 || at[0] != 15 || at[1] != 23) begin
         errors++;
         $display("FAIL basic_bytes: got %0d strobes (%p at %p) want 2 strobes 12,34 at 15,23", got.size(), got, at);
      end
   endtask

   task automatic test_no_sync();
      int n_en = 0;
      apply_reset();
      repeat (64) add_bit(1'b0, 1'b0);
      repeat (4) add_byte(8'hFF);
      foreach (stim[i]) begin
         send_bit(stim[i], sbad[i]);
         checks++;
         if ({lane.enable_o, lane.synced_o, lane.data_o} !== {m_en, m_sync, m_data}) begin
            errors++;
            $display("FAIL no_sync bit %0d: got en=%b sync=%b data=%h want en=%b sync=%b data=%h", i, lane.enable_o, lane.synced_o, lane.data_o, m_en, m_sync, m_data);
         end
         n_en += int'(lane.enable_o);
      end
      checks++;
      if (n_en != 0 || lane.synced_o !== 1'b0 || lane.data_o !== 8'h00) begin
         errors++;
         $display("FAIL no_sync_final: got strobes=%0d sync=%b data=%h want 0 0 00", n_en, lane.synced_o, lane.data_o);
      end
   endtask

   task automatic test_misaligned();
      bit [7:0] got[$];
      apply_reset();
      repeat (3) add_bit(1'($urandom_range(1)), 1'b0);
      add_byte(SYNC_BYTE_DEFAULT);
      add_byte(8'hA5);
      foreach (stim[i]) begin
         send_bit(stim[i], sbad[i]);
         checks++;
         if ({lane.enable_o, lane.synced_o, lane.data_o} !== {m_en, m_sync, m_data}) begin
            errors++;
            $display("FAIL misaligned bit %0d: got en=%b sync=%b data=%h want en=%b sync=%b data=%h", i, lane.enable_o, lane.synced_o, lane.data_o, m_en, m_sync, m_data);
         end
         if (lane.enable_o) got.push_back(lane.data_o);
      end
      checks++;
      if (got.size() != 1 || got[0] !== 8'hA5) begin
         errors++;
         $display("FAIL misaligned_bytes: got %p want single A5", got);
      end
   endtask

   task automatic test_sync_payload();
      bit [7:0] got[$];
      apply_reset();
      add_byte(SYNC_BYTE_DEFAULT);
      add_byte(8'hB8);
      add_byte(8'h01);
      foreach (stim[i]) begin
         send_bit(stim[i], sbad[i]);
         checks++;
         if ({lane.enable_o, lane.synced_o, lane.data_o} !== {m_en, m_sync, m_data}) begin
            errors++;
            $display("FAIL sync_payload bit %0d: got en=%b sync=%b data=%h want en=%b sync=%b data=%h", i, lane.enable_o, lane.synced_o, lane.data_o, m_en, m_sync, m_data);
         end
         if (lane.enable_o) got.push_back(lane.data_o);
      end
      checks++;
      if (got.size() != 2 || got[0] !== 8'hB8 || got[1] !== 8'h01) begin
         errors++;
         $display("FAIL sync_payload_bytes: got %p want B8,01", got);
      end
   endtask

   task automatic test_mid_reset();
      bit [7:0] got[$];
      apply_reset();
      add_byte(SYNC_BYTE_DEFAULT);
      add_byte(8'hC3);
      for (int i = 0; i < 12; i++) send_bit(stim[i], sbad[i]);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({lane.enable_o, lane.synced_o, lane.data_o} !== 10'h000) begin
         errors++;
         $display("FAIL mid_reset_async: got en=%b sync=%b data=%h want 0 0 00", lane.enable_o, lane.synced_o, lane.data_o);
      end
      apply_reset();
      // Reset landing on the edge that completes a byte must suppress its strobe.
      add_byte(SYNC_BYTE_DEFAULT);
      add_byte(8'h77);
      for (int i = 0; i < 15; i++) send_bit(stim[i], sbad[i]);
      @(negedge clk);
      lane.data_p_i = stim[15];
      lane.data_n_i = ~stim[15];
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({lane.enable_o, lane.synced_o, lane.data_o} !== 10'h000) begin
         errors++;
         $display("FAIL reset_at_byte_end: got en=%b sync=%b data=%h want 0 0 00", lane.enable_o, lane.synced_o, lane.data_o);
      end
      apply_reset();
      add_byte(SYNC_BYTE_DEFAULT);
      add_byte(8'h5A);
      foreach (stim[i]) begin
         send_bit(stim[i], sbad[i]);
         checks++;
         if ({lane.enable_o, lane.synced_o, lane.data_o} !== {m_en, m_sync, m_data}) begin
            errors++;
            $display("FAIL mid_reset bit %0d: got en=%b sync=%b data=%h want en=%b sync=%b data=%h", i, lane.enable_o, lane.synced_o, lane.data_o, m_en, m_sync, m_data);
         end
         if (lane.enable_o) got.push_back(lane.data_o);
      end
      checks++;
      if (got.size() != 1 || got[0] !== 8'h5A) begin
         errors++;
         $display("FAIL mid_reset_bytes: got %p want single 5A", got);
      end
   endtask

   task automatic test_diff_check();
      bit [7:0] got[$];
      int n_bad_en = 0;
      apply_reset();
      add_byte(SYNC_BYTE_DEFAULT);
      repeat (3) add_bit(1'b1, 1'b0);
      add_bit(1'b0, 1'b1);
      repeat (4) add_bit(1'b0, 1'b0);
      add_byte(SYNC_BYTE_DEFAULT);
      add_byte(8'h3C);
      foreach (stim[i]) begin
         send_bit(stim[i], sbad[i]);
         checks++;
         if ({lane.enable_o, lane.synced_o, lane.data_o} !== {m_en, m_sync, m_data}) begin
            errors++;
            $display("FAIL diff bit %0d: got en=%b sync=%b data=%h want en=%b sync=%b data=%h", i, lane.enable_o, lane.synced_o, lane.data_o, m_en, m_sync, m_data);
         end
         if (i >= 8 && i < 16) n_bad_en += int'(lane.enable_o) + int'(i == 11 && lane.synced_o);
         if (lane.enable_o) got.push_back(lane.data_o);
      end
      checks++;
      if (n_bad_en != 0 || got.size() != 1 || got[0] !== 8'h3C) begin
         errors++;
         $display("FAIL diff_bytes: got bad_events=%0d bytes=%p want 0 and single 3C", n_bad_en, got);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(15) == 0) add_byte(SYNC_BYTE_DEFAULT);
         else add_bit(1'($urandom_range(1)), DIFF && $urandom_range(39) == 0);
      end
      foreach (stim[i]) begin
         send_bit(stim[i], sbad[i]);
         checks++;
         if ({lane.enable_o, lane.synced_o, lane.data_o} !== {m_en, m_sync, m_data}) begin
            errors++;
            $display("FAIL random bit %0d: got en=%b sync=%b data=%h want en=%b sync=%b data=%h", i, lane.enable_o, lane.synced_o, lane.data_o, m_en, m_sync, m_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_no_sync();
      test_misaligned();
      test_sync_payload();
      test_mid_reset();
      if (DIFF) test_diff_check();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
